// File: rtl/logic74_pkg.sv
// rtl/logic74_pkg.sv - shared FSM encodings and width helper for the 74-series models
// Contents:
//   rx_state_e : receiver FSM states, ST_IDLE=1'b0 and ST_RECV=1'b1
//   clog2      : ceil(log2(value)); callers pass WIDTH+1 to size a 0..WIDTH counter
package logic74_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_rx8_if.sv
// rtl/shift_rx8_if.sv - serial input and word output bundle of the shift_rx8 receiver
// Signals:
//   sin, shen, sync      : serial data, shift enable, word-start marker (source -> receiver)
//   dack, ovr_clr        : consumer acknowledge, sticky flag clear (consumer -> receiver)
//   dout, dvalid, busy   : completed word, word pending, partial word in progress (receiver -> consumer)
//   ovr, ferr            : sticky overrun and framing-error flags (receiver -> consumer)
// Modports: master = source/consumer side, slave = receiver.
interface shift_rx8_if #(
  parameter int WIDTH = 8
);
  logic             sin;
  logic             shen;
  logic             sync;
  logic             dack;
  logic             ovr_clr;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             busy;
  logic             ovr;
  logic             ferr;

  modport master (
    output sin, shen, sync, dack, ovr_clr,
    input  dout, dvalid, busy, ovr, ferr
  );

  modport slave (
    input  sin, shen, sync, dack, ovr_clr,
    output dout, dvalid, busy, ovr, ferr
  );
endinterface

// File: rtl/shift_rx8_bitcnt.sv
// rtl/shift_rx8_bitcnt.sv - received-bit counter (0..WIDTH) for shift_rx8
// Ports:
//   clk, nclr : clock, asynchronous active-low reset (count returns to 0)
//   clr_i     : clear to 0 (highest priority)
//   load1_i   : load 1 (first bit of a word accepted)
//   inc_i     : increment by one
//   term_o    : count equals WIDTH-1, so the next accepted bit completes the word
module shift_rx8_bitcnt
  import logic74_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic nclr,
  input  logic clr_i,
  input  logic load1_i,
  input  logic inc_i,
  output logic term_o
);
  localparam int CW = clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (load1_i) cnt_d = CW'(1);
    else if (inc_i)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CW'(WIDTH - 1));
endmodule

// File: rtl/shift_rx8.sv
// rtl/shift_rx8.sv - serial-to-parallel word receiver with valid/ack output register
// Ports:
//   clk  : system clock, rising edge
//   nclr : asynchronous active-low reset
//   rx   : shift_rx8_if.slave (sin/shen/sync/dack/ovr_clr in; dout/dvalid/busy/ovr/ferr out)
// Build option SHIFT_RX_OVERWRITE_EN: on overrun the newest word replaces the
// unconsumed one; when undefined the newest word is dropped. ovr is set either way.
module shift_rx8
  import logic74_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          nclr,
  shift_rx8_if.slave    rx
);
  rx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic             cnt_clr, cnt_load1, cnt_inc, cnt_term;
  logic             complete;
  logic [WIDTH-1:0] word;

  shift_rx8_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk     (clk),
    .nclr    (nclr),
    .clr_i   (cnt_clr),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .term_o  (cnt_term)
  );

  // The completing bit goes straight to the output stage, not via sr.
  assign word = {sr_q[WIDTH-2:0], rx.sin};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    complete  = 1'b0;

    // Clear first so a set later in this block wins in the same cycle.
    if (rx.ovr_clr) begin
      ovr_d  = 1'b0;
      ferr_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx.shen && rx.sync) begin
          sr_d      = {{(WIDTH-1){1'b0}}, rx.sin};
          cnt_load1 = 1'b1;
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx.shen) begin
          if (rx.sync) begin
            // Early sync: drop the partial word and restart on this bit.
            sr_d      = {{(WIDTH-1){1'b0}}, rx.sin};
            cnt_load1 = 1'b1;
            ferr_d    = 1'b1;
          end else if (cnt_term) begin
            sr_d     = word;
            cnt_clr  = 1'b1;
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            sr_d    = word;
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if (!dvalid_q || rx.dack) begin
        dout_d   = word;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
`ifdef SHIFT_RX_OVERWRITE_EN
        dout_d = word;
`else
        dout_d = dout_q;
`endif
      end
    end else if (rx.dack && dvalid_q) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx.dout   = dout_q;
  assign rx.dvalid = dvalid_q;
  assign rx.busy   = (state_q == ST_RECV);
  assign rx.ovr    = ovr_q;
  assign rx.ferr   = ferr_q;
endmodule

// File: tb/tb_shift_rx8.sv
// tb/tb_shift_rx8.sv - self-checking scoreboard bench for shift_rx8
module tb_shift_rx8;
  localparam int W = 8;

  logic clk  = 1'b0;
  logic nclr = 1'b0;

  shift_rx8_if #(.WIDTH(W)) rx ();

  shift_rx8 #(.WIDTH(W)) dut (
    .clk  (clk),
    .nclr (nclr),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got 0x%0h", tag, rx.dout);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dout"}, 32'(rx.dout), 32'(e));
      check({tag, "_dvalid"}, 32'(rx.dvalid), 32'd1);
    end
  endtask

  // Entered and left at a falling edge; the bit is sampled on the rising edge between.
  task automatic put_bit(input logic b, input logic s);
    rx.sin  = b;
    rx.shen = 1'b1;
    rx.sync = s;
    @(negedge clk);
    rx.shen = 1'b0;
    rx.sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) put_bit(w[i], i == W - 1);
  endtask

  task automatic pulse_dack();
    rx.dack = 1'b1;
    @(negedge clk);
    rx.dack = 1'b0;
  endtask

  task automatic pulse_clr();
    rx.ovr_clr = 1'b1;
    @(negedge clk);
    rx.ovr_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},   32'(rx.dout),   32'd0);
    check({tag, "_dvalid"}, 32'(rx.dvalid), 32'd0);
    check({tag, "_busy"},   32'(rx.busy),   32'd0);
    check({tag, "_ovr"},    32'(rx.ovr),    32'd0);
    check({tag, "_ferr"},   32'(rx.ferr),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    int gap;

    rx.sin = 1'b0; rx.shen = 1'b0; rx.sync = 1'b0; rx.dack = 1'b0; rx.ovr_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    nclr = 1'b1;
    @(negedge clk);

    // Single word, consecutive bits
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    expect_word("a5");
    check("a5_busy", 32'(rx.busy), 32'd0);
    check("a5_ovr",  32'(rx.ovr),  32'd0);
    check("a5_ferr", 32'(rx.ferr), 32'd0);
    pulse_dack();
    check("a5_ack_dvalid", 32'(rx.dvalid), 32'd0);

    // Gapped word: gaps cycle through 0, 1, 5 idle clocks
    w = 8'h3C;
    exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      put_bit(w[i], i == W - 1);
      if (i > 0) begin
        gap = ((i % 3) == 0) ? 0 : (((i % 3) == 1) ? 1 : 5);
        for (int g = 0; g < gap; g++) begin
          idle(1);
          check("3c_gap_busy", 32'(rx.busy), 32'd1);
        end
      end
    end
    expect_word("3c");
    pulse_dack();

    // Overrun
    exp_q.push_back(8'h11);
    send_word(8'h11);
    expect_word("ovr_first");
    send_word(8'h22);
`ifdef SHIFT_RX_OVERWRITE_EN
    exp_q.push_back(8'h22);
`else
    exp_q.push_back(8'h11);
`endif
    expect_word("ovr_second");
    check("ovr_set", 32'(rx.ovr), 32'd1);
    pulse_clr();
    check("ovr_cleared", 32'(rx.ovr), 32'd0);
    pulse_dack();
    check("ovr_ack_dvalid", 32'(rx.dvalid), 32'd0);

    // Framing error: sync again after 4 bits
    put_bit(1'b1, 1'b1);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b1, 1'b0);
    check("ferr_partial_dvalid", 32'(rx.dvalid), 32'd0);
    check("ferr_partial_busy",   32'(rx.busy),   32'd1);
    exp_q.push_back(8'hF0);
    send_word(8'hF0);
    check("ferr_set", 32'(rx.ferr), 32'd1);
    expect_word("f0");
    pulse_clr();
    check("ferr_cleared", 32'(rx.ferr), 32'd0);
    pulse_dack();

    // Back-to-back words, dack in the completion cycle of the second
    exp_q.push_back(8'h81);
    send_word(8'h81);
    expect_word("b2b_81");
    w = 8'h7E;
    exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) rx.dack = 1'b1;
      put_bit(w[i], i == W - 1);
      rx.dack = 1'b0;
    end
    expect_word("b2b_7e");
    check("b2b_ovr", 32'(rx.ovr), 32'd0);

    // Reset mid-word (7E still pending so dout must visibly clear)
    for (int i = 0; i < 5; i++) put_bit(1'b1, i == 0);
    check("mid_busy", 32'(rx.busy), 32'd1);
    nclr = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    nclr = 1'b1;
    for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
    check("nosync_busy",   32'(rx.busy),   32'd0);
    check("nosync_dvalid", 32'(rx.dvalid), 32'd0);
    exp_q.push_back(8'h55);
    send_word(8'h55);
    expect_word("55");
    check("55_ferr", 32'(rx.ferr), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
